full_adder_using_half_adders: RTL and testbench
===============================================

// Module: full_adder_using_half_adders
// PURPOSE
//   Binary full adder built hierarchically from two half adders plus an OR for carry.
//   Adds A + B + Cin and gives Sum and Cout combinationally, with zero latency.
//   It also provides a registered copy of the result for pipelined consumers.
//   Leaf arithmetic cell of the adder library; ripple/wider adders instantiate it.
// PARAMETERS
//   WIDTH  1  operand width in bits; WIDTH>1 builds a ripple chain of full-adder slices
// PORTS
//   clk     in   1      rising-edge clock, used only by the registered outputs
//   rst     in   1      asynchronous, active-high reset
//   A       in   WIDTH  addend
//   B       in   WIDTH  addend
//   Cin     in   1      carry in to bit 0
//   Sum     out  WIDTH  combinational sum bits
//   Cout    out  1      combinational carry out of the MSB slice
//   Sum_q   out  WIDTH  Sum registered on clk
//   Cout_q  out  1      Cout registered on clk
// BEHAVIOUR
//   - One clock (clk); reset rst is asynchronous and active-high.
//   - Combinational path, one slice per bit i:
//       HA0: s0 = A[i]^B[i], c0 = A[i]&B[i]
//       HA1: Sum[i] = s0^c_in(i), c1 = s0&c_in(i)
//       c_out(i) = c0 | c1
//       c_in(0) = Cin; c_in(i) = c_out(i-1); Cout = c_out(WIDTH-1)
//   - Arithmetic: {Cout,Sum} == A + B + Cin exactly, computed at WIDTH+1 bits, unsigned.
//     No overflow flag; wrap-around appears only as Cout=1.
//   - Sum and Cout are purely combinational. They are independent of clk and rst and
//     settle within the same delta as input changes (latency 0).
//   - Registered path (latency 1):
//       on posedge clk, Sum_q <= Sum and Cout_q <= Cout.
//   - Reset: rst=1 immediately forces Sum_q=0 and Cout_q=0, regardless of clk.
//     Sum and Cout keep tracking the inputs during reset.
//   - Reset deasserted mid-operation: the first capture is on the next posedge clk.
//   - Inputs X/Z: outputs follow 4-state gate semantics; no masking.
//   - No handshake and no state machine; all input combinations are legal every cycle.
// STRUCTURE
//   - Sub-module half_adder (a, b -> s = a^b, c = a&b); two instances per slice.
//   - Slices are generated with a generate-for over WIDTH. The carry OR stays in
//     the parent module.
//   - Shared package adder_pkg: default width constant ADDER_W_DEFAULT=1 and
//     typedef sum_cout_t (packed {cout, sum}) for consumers.
//   - Register stage lives in this module; there is no separate register sub-module.
// TESTING
//   - WIDTH=1 exhaustive, 10 time units per vector over all 8 {A,B,Cin}:
//       000->S0C0, 001->10, 010->10, 011->01, 100->10, 101->01, 110->01, 111->S1C1.
//   - Combinational check with clk held low and rst=1:
//       A=1,B=1,Cin=1 -> Sum=1,Cout=1 immediately; Sum_q=0, Cout_q=0.
//   - Register latency: rst=0, apply A=1,B=0,Cin=1, then one posedge
//       -> Sum_q=0, Cout_q=1 after that edge; no change before it.
//   - Async reset mid-run: Sum_q=1 held, assert rst between clock edges
//       -> Sum_q=0 and Cout_q=0 without waiting for a clock edge.
//   - WIDTH=4 wrap-around: A=4'hF, B=4'h1, Cin=0 -> Sum=4'h0, Cout=1.
//     Also A=4'hF, B=4'hF, Cin=1 -> Sum=4'hF, Cout=1.
//   - WIDTH=4 random: 200 random vectors, compare {Cout,Sum} against A+B+Cin
//     every vector, and Sum_q/Cout_q against the previous cycle's values.

Source files
------------

// File: rtl/adder_pkg.sv
// Shared definitions for the adder library.
//   ADDER_W_DEFAULT : default operand width of the leaf full adder
//   sum_cout_t      : packed {cout, sum} result word for downstream consumers
//   pack_result     : helper that builds a sum_cout_t from separate carry/sum
package adder_pkg;

  localparam int unsigned ADDER_W_DEFAULT = 1;

  typedef struct packed {
    logic                       cout;
    logic [ADDER_W_DEFAULT-1:0] sum;
  } sum_cout_t;

  function automatic sum_cout_t pack_result(input logic cout,
                                            input logic [ADDER_W_DEFAULT-1:0] sum);
    sum_cout_t r;
    r.cout = cout;
    r.sum  = sum;
    return r;
  endfunction

endpackage

// File: rtl/half_adder.sv
// One-bit half adder: the arithmetic primitive of each full-adder slice.
//   a, b : input bits
//   s    : sum bit   (a ^ b)
//   c    : carry bit (a & b)
module half_adder (
  input  logic a,
  input  logic b,
  output logic s,
  output logic c
);

  assign s = a ^ b;
  assign c = a & b;

endmodule

// File: rtl/full_adder_using_half_adders.sv
// Full adder built from two half adders per bit plus an OR for the carry.
// WIDTH > 1 chains slices into a ripple-carry adder. Sum/Cout are combinational;
// Sum_q/Cout_q are the same result registered on clk.
//   clk    : rising-edge clock for the registered outputs only
//   rst    : asynchronous, active-high reset of Sum_q/Cout_q
//   A, B   : WIDTH-bit addends
//   Cin    : carry into bit 0
//   Sum    : combinational sum, WIDTH bits
//   Cout   : combinational carry out of the MSB slice
//   Sum_q  : Sum registered on clk
//   Cout_q : Cout registered on clk
module full_adder_using_half_adders
  import adder_pkg::*;
#(
  parameter int unsigned WIDTH = ADDER_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout,
  output logic [WIDTH-1:0] Sum_q,
  output logic             Cout_q
);

  // carry[i] feeds slice i; carry[WIDTH] leaves the MSB slice
  logic [WIDTH:0] carry;

  assign carry[0] = Cin;

  // One slice per bit; the carry OR is kept here rather than in a wrapper cell
  for (genvar i = 0; i < WIDTH; i++) begin : g_slice
    logic s0;
    logic c0;
    logic c1;

    half_adder u_ha0 (
      .a (A[i]),
      .b (B[i]),
      .s (s0),
      .c (c0)
    );

    half_adder u_ha1 (
      .a (s0),
      .b (carry[i]),
      .s (Sum[i]),
      .c (c1)
    );

    assign carry[i+1] = c0 | c1;
  end

  assign Cout = carry[WIDTH];

  // Registered copy of the result for pipelined consumers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      Sum_q  <= '0;
      Cout_q <= 1'b0;
    end else begin
      Sum_q  <= Sum;
      Cout_q <= Cout;
    end
  end

endmodule

// File: tb/tb_full_adder_using_half_adders.sv
// Self-checking bench for full_adder_using_half_adders at WIDTH=1 and WIDTH=4.
module tb_full_adder_using_half_adders;

  logic       clk;
  logic       clk_en;
  logic       rst;

  logic       a1, b1, cin1;
  logic       sum1, cout1, sum_q1, cout_q1;

  logic [3:0] a4, b4;
  logic       cin4;
  logic [3:0] sum4, sum_q4;
  logic       cout4, cout_q4;

  int checks;
  int failures;

  logic [4:0] exp_q[$];

  full_adder_using_half_adders #(.WIDTH(1)) u_dut1 (
    .clk    (clk),
    .rst    (rst),
    .A      (a1),
    .B      (b1),
    .Cin    (cin1),
    .Sum    (sum1),
    .Cout   (cout1),
    .Sum_q  (sum_q1),
    .Cout_q (cout_q1)
  );

  full_adder_using_half_adders #(.WIDTH(4)) u_dut4 (
    .clk    (clk),
    .rst    (rst),
    .A      (a4),
    .B      (b4),
    .Cin    (cin4),
    .Sum    (sum4),
    .Cout   (cout4),
    .Sum_q  (sum_q4),
    .Cout_q (cout_q4)
  );

  // Gated clock: held low until clk_en is raised
  initial begin
    clk = 1'b0;
    forever begin
      #5;
      if (clk_en) clk = ~clk;
      else        clk = 1'b0;
    end
  end

  task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  initial begin
    logic [1:0] e1;
    logic [4:0] e4;
    logic [4:0] popped;
    logic [2:0] v;

    checks   = 0;
    failures = 0;
    clk_en   = 1'b0;
    rst      = 1'b1;
    a1 = 1'b0; b1 = 1'b0; cin1 = 1'b0;
    a4 = 4'h0; b4 = 4'h0; cin4 = 1'b0;
    #1;

    check_eq("reset_sum_q1",  8'(sum_q1),  8'h00);
    check_eq("reset_cout_q1", 8'(cout_q1), 8'h00);
    check_eq("reset_sum_q4",  8'(sum_q4),  8'h00);

    // Exhaustive WIDTH=1, combinational path works during reset
    for (int i = 0; i < 8; i++) begin
      v = 3'(i);
      a1 = v[2]; b1 = v[1]; cin1 = v[0];
      #10;
      e1 = 2'(a1) + 2'(b1) + 2'(cin1);
      check_eq($sformatf("w1_vec%0d", i), 8'({cout1, sum1}), 8'(e1));
      check_eq($sformatf("w1_vec%0d_q", i), 8'({cout_q1, sum_q1}), 8'h00);
    end

    a1 = 1'b1; b1 = 1'b1; cin1 = 1'b1;
    #1;
    check_eq("comb_111_sum",  8'(sum1),    8'h01);
    check_eq("comb_111_cout", 8'(cout1),   8'h01);
    check_eq("comb_111_sumq", 8'(sum_q1),  8'h00);
    check_eq("comb_111_coq",  8'(cout_q1), 8'h00);

    // Register latency
    rst = 1'b0;
    a1 = 1'b1; b1 = 1'b0; cin1 = 1'b1;
    #3;
    check_eq("lat_pre_sumq",  8'(sum_q1),  8'h00);
    check_eq("lat_pre_coutq", 8'(cout_q1), 8'h00);
    clk_en = 1'b1;
    @(posedge clk); #1;
    check_eq("lat_post_sumq",  8'(sum_q1),  8'h00);
    check_eq("lat_post_coutq", 8'(cout_q1), 8'h01);

    // Async reset between edges
    a1 = 1'b1; b1 = 1'b0; cin1 = 1'b0;
    @(posedge clk); #1;
    check_eq("held_sumq", 8'(sum_q1), 8'h01);
    #1 rst = 1'b1;
    #1;
    check_eq("async_rst_sumq",  8'(sum_q1),  8'h00);
    check_eq("async_rst_coutq", 8'(cout_q1), 8'h00);
    @(negedge clk) rst = 1'b0;
    #1;
    check_eq("rst_release_noedge", 8'(sum_q1), 8'h00);
    @(posedge clk); #1;
    check_eq("first_capture_sumq", 8'(sum_q1), 8'h01);

    // WIDTH=4 wrap-around corners
    @(negedge clk);
    a4 = 4'hF; b4 = 4'h1; cin4 = 1'b0;
    #1;
    check_eq("w4_f_plus_1", 8'({cout4, sum4}), 8'h10);
    a4 = 4'hF; b4 = 4'hF; cin4 = 1'b1;
    #1;
    check_eq("w4_f_f_1", 8'({cout4, sum4}), 8'h1F);

    // WIDTH=4 random with a one-deep registered scoreboard
    exp_q.delete();
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      a4   = 4'($urandom_range(0, 15));
      b4   = 4'($urandom_range(0, 15));
      cin4 = 1'($urandom_range(0, 1));
      e4   = 5'(a4) + 5'(b4) + 5'(cin4);
      exp_q.push_back(e4);
      #1;
      check_eq($sformatf("w4_rand%0d", n), 8'({cout4, sum4}), 8'(e4));
      @(posedge clk); #1;
      if (exp_q.size() == 0) begin
        check_eq("w4_sb_empty", 8'h01, 8'h00);
      end else begin
        popped = exp_q.pop_front();
        check_eq($sformatf("w4_rand%0d_q", n), 8'({cout_q4, sum_q4}), 8'(popped));
      end
    end
    check_eq("w4_sb_drained", 8'(exp_q.size()), 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
